// File: rtl/centroid_pkg.sv
// ---------------------------------------------------------------------------
// centroid_pkg
// Shared constants for the centroid post-processing controller:
//   DEF_SUM_S_WIDTH   - default width of the pixel-count sum S (divisor)
//   DEF_SUM_XY_WIDTH  - default width of the SX / SY sums (dividends)
//   DEF_FRAC_BITS     - default fractional bits of each centroid coordinate
//   state_t           - sequencer state encoding, also exported on oSTATE
// ---------------------------------------------------------------------------
package centroid_pkg;

  localparam int DEF_SUM_S_WIDTH  = 20;
  localparam int DEF_SUM_XY_WIDTH = 28;
  localparam int DEF_FRAC_BITS    = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DIV_X = 3'd1,
    ST_DIV_Y = 3'd2,
    ST_OUT   = 3'd3
  } state_t;

endpackage

// File: rtl/centroid_div_sched_serial_udiv.sv
// ---------------------------------------------------------------------------
// serial_udiv
// Serial restoring unsigned divider, one quotient bit per clock, MSB first.
// Q_W iterations are run; the dividend is expected to be Q_W bits wide
// (DVD_W == Q_W).
//   CCLK       clock
//   RST_N      asynchronous active-low reset (iteration counter only)
//   iSTART     load cycle: capture dividend/divisor, clear remainder
//   iDIVIDEND  DVD_W-bit unsigned dividend
//   iDIVISOR   DVS_W-bit unsigned divisor (zero-extended internally)
//   oDONE      high during the final iteration cycle
//   oQUOT      full quotient, valid while oDONE is high
// ---------------------------------------------------------------------------
module serial_udiv #(
  parameter int DVD_W = 32,
  parameter int DVS_W = 20,
  parameter int Q_W   = DVD_W
) (
  input  logic             CCLK,
  input  logic             RST_N,
  input  logic             iSTART,
  input  logic [DVD_W-1:0] iDIVIDEND,
  input  logic [DVS_W-1:0] iDIVISOR,
  output logic             oDONE,
  output logic [Q_W-1:0]   oQUOT
);

  localparam int CW = $clog2(Q_W + 1);

  logic [CW-1:0]    cnt;
  logic [DVS_W:0]   rem;
  logic [DVD_W-1:0] dvd;
  logic [DVS_W-1:0] dvs;
  logic [Q_W-2:0]   quo;

  logic [DVS_W+1:0]        shifted;
  logic signed [DVS_W+1:0] diff;
  logic                    qbit;
  logic [Q_W-1:0]          quo_nxt;

  // Trial subtraction; the remainder is always below the divisor, so one
  // extra bit above the shifted remainder is enough to carry the sign.
  assign shifted = {rem, dvd[DVD_W-1]};
  assign diff    = signed'(shifted) - signed'({2'b00, dvs});
  assign qbit    = ~diff[DVS_W+1];
  assign quo_nxt = {quo, qbit};

  assign oDONE = (cnt == CW'(1));
  assign oQUOT = quo_nxt;

  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (iSTART) begin
      cnt <= CW'(Q_W);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge CCLK) begin
    if (iSTART) begin
      rem <= '0;
      dvd <= iDIVIDEND;
      dvs <= iDIVISOR;
      quo <= '0;
    end else if (cnt != '0) begin
      rem <= qbit ? diff[DVS_W:0] : shifted[DVS_W:0];
      dvd <= {dvd[DVD_W-2:0], 1'b0};
      quo <= quo_nxt[Q_W-2:0];
    end
  end

endmodule

// File: rtl/centroid_div_sched.sv
// ---------------------------------------------------------------------------
// centroid_div_sched
// Captures S/SX/SY on a start trigger, runs X then Y through one shared
// serial divider computing floor((D << FRAC_BITS) / S), saturates, and
// presents the centroid with a valid/ready handshake.
//   CCLK, RST_N        clock, asynchronous active-low reset
//   iSTART_TRIG        capture request, sampled only in IDLE
//   iSUM_S/SX/SY       accumulator sums
//   oBUSY              high from capture until the result is accepted
//   oVALID, iREADY     result handshake
//   oCX, oCY           unsigned fixed-point centroid (ADDR_WIDTH.FRAC_BITS)
//   oNO_TARGET         S was zero
//   oOVF               either quotient saturated
//   oSTATE             debug state (IDLE=0, DIV_X=1, DIV_Y=2, OUT=3)
// Build option: define CENTROID_DIV_ROUND_EN to round half up (one extra
// divider iteration per coordinate) instead of truncating.
// ---------------------------------------------------------------------------
module centroid_div_sched
  import centroid_pkg::*;
#(
  parameter int ADDR_WIDTH   = 11,
  parameter int FRAC_BITS    = DEF_FRAC_BITS,
  parameter int SUM_S_WIDTH  = DEF_SUM_S_WIDTH,
  parameter int SUM_XY_WIDTH = DEF_SUM_XY_WIDTH,
  localparam int OW          = ADDR_WIDTH + FRAC_BITS
) (
  input  logic                    CCLK,
  input  logic                    RST_N,
  input  logic                    iSTART_TRIG,
  input  logic [SUM_S_WIDTH-1:0]  iSUM_S,
  input  logic [SUM_XY_WIDTH-1:0] iSUM_SX,
  input  logic [SUM_XY_WIDTH-1:0] iSUM_SY,
  output logic                    oBUSY,
  output logic                    oVALID,
  input  logic                    iREADY,
  output logic [OW-1:0]           oCX,
  output logic [OW-1:0]           oCY,
  output logic                    oNO_TARGET,
  output logic                    oOVF,
  output logic [2:0]              oSTATE
);

`ifdef CENTROID_DIV_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int N  = SUM_XY_WIDTH + FRAC_BITS;
  localparam int QW = N + RND;

  state_t state, state_nxt;
  logic   first;
  logic [SUM_S_WIDTH-1:0]  s_q;
  logic [SUM_XY_WIDTH-1:0] sx_q, sy_q;

  logic          capture, enter_div, div_start, zero_out, lat_x, lat_y, accept;
  logic          div_done;
  logic [QW-1:0] div_quot, div_dvd;
  logic [OW:0]   qfix;

  // With rounding the divider produces one extra fraction bit; fold it in.
  function automatic logic [QW-1:0] round_q(input logic [QW-1:0] q);
`ifdef CENTROID_DIV_ROUND_EN
    return (q >> 1) + QW'(q[0]);
`else
    return q;
`endif
  endfunction

  // Returns {overflow, clamped value}.
  function automatic logic [OW:0] sat_q(input logic [QW-1:0] q);
    if (|q[QW-1:OW]) return {1'b1, {OW{1'b1}}};
    else             return {1'b0, q[OW-1:0]};
  endfunction

  assign div_dvd = {((state == ST_DIV_X) ? sx_q : sy_q), {(FRAC_BITS + RND){1'b0}}};
  assign qfix    = sat_q(round_q(div_quot));

  serial_udiv #(
    .DVD_W (QW),
    .DVS_W (SUM_S_WIDTH),
    .Q_W   (QW)
  ) u_div (
    .CCLK      (CCLK),
    .RST_N     (RST_N),
    .iSTART    (div_start),
    .iDIVIDEND (div_dvd),
    .iDIVISOR  (s_q),
    .oDONE     (div_done),
    .oQUOT     (div_quot)
  );

  // The first cycle in each DIV state is the divider load cycle; the zero
  // divisor check happens there, which puts oVALID two cycles after capture.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    enter_div = 1'b0;
    div_start = 1'b0;
    zero_out  = 1'b0;
    lat_x     = 1'b0;
    lat_y     = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (iSTART_TRIG) begin
          capture   = 1'b1;
          enter_div = 1'b1;
          state_nxt = ST_DIV_X;
        end
      end
      ST_DIV_X: begin
        if (first) begin
          if (s_q == '0) begin
            zero_out  = 1'b1;
            state_nxt = ST_OUT;
          end else begin
            div_start = 1'b1;
          end
        end else if (div_done) begin
          lat_x     = 1'b1;
          enter_div = 1'b1;
          state_nxt = ST_DIV_Y;
        end
      end
      ST_DIV_Y: begin
        if (first) begin
          div_start = 1'b1;
        end else if (div_done) begin
          lat_y     = 1'b1;
          state_nxt = ST_OUT;
        end
      end
      ST_OUT: begin
        if (oVALID && iREADY) begin
          accept    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      first      <= 1'b0;
      s_q        <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      oCX        <= '0;
      oCY        <= '0;
      oNO_TARGET <= 1'b0;
      oOVF       <= 1'b0;
      oVALID     <= 1'b0;
      oBUSY      <= 1'b0;
    end else begin
      state <= state_nxt;
      first <= enter_div;
      if (capture) begin
        s_q        <= iSUM_S;
        sx_q       <= iSUM_SX;
        sy_q       <= iSUM_SY;
        oBUSY      <= 1'b1;
        oOVF       <= 1'b0;
        oNO_TARGET <= 1'b0;
      end
      if (zero_out) begin
        oCX        <= '0;
        oCY        <= '0;
        oNO_TARGET <= 1'b1;
        oVALID     <= 1'b1;
      end
      if (lat_x) begin
        oCX  <= qfix[OW-1:0];
        oOVF <= qfix[OW];
      end
      if (lat_y) begin
        oCY    <= qfix[OW-1:0];
        oOVF   <= oOVF | qfix[OW];
        oVALID <= 1'b1;
      end
      if (accept) begin
        oVALID <= 1'b0;
        oBUSY  <= 1'b0;
      end
    end
  end

  assign oSTATE = state;

endmodule

// File: tb/tb_centroid_div_sched.sv
module tb_centroid_div_sched;

  localparam int OW  = 15;
  localparam int FB  = 4;
`ifdef CENTROID_DIV_ROUND_EN
  localparam int LAT = 2 * 32 + 5;
`else
  localparam int LAT = 2 * 32 + 3;
`endif

  typedef struct packed {
    logic [OW-1:0] cx;
    logic [OW-1:0] cy;
    logic          nt;
    logic          ovf;
  } exp_t;

  logic          CCLK = 1'b0;
  logic          RST_N;
  logic          iSTART_TRIG;
  logic [19:0]   iSUM_S;
  logic [27:0]   iSUM_SX, iSUM_SY;
  logic          oBUSY, oVALID, iREADY;
  logic [OW-1:0] oCX, oCY;
  logic          oNO_TARGET, oOVF;
  logic [2:0]    oSTATE;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  centroid_div_sched dut (
    .CCLK        (CCLK),
    .RST_N       (RST_N),
    .iSTART_TRIG (iSTART_TRIG),
    .iSUM_S      (iSUM_S),
    .iSUM_SX     (iSUM_SX),
    .iSUM_SY     (iSUM_SY),
    .oBUSY       (oBUSY),
    .oVALID      (oVALID),
    .iREADY      (iREADY),
    .oCX         (oCX),
    .oCY         (oCY),
    .oNO_TARGET  (oNO_TARGET),
    .oOVF        (oOVF),
    .oSTATE      (oSTATE)
  );

  always #5 CCLK = ~CCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] quot(input logic [27:0] d, input logic [19:0] s);
    logic [63:0] dd, ss;
    dd = 64'(d);
    ss = 64'(s);
`ifdef CENTROID_DIV_ROUND_EN
    return (((dd << (FB + 1)) / ss) + 64'd1) >> 1;
`else
    return (dd << FB) / ss;
`endif
  endfunction

  function automatic exp_t model(input logic [19:0] s, input logic [27:0] sx, input logic [27:0] sy);
    exp_t e;
    logic [63:0] qx, qy, lim;
    lim = 64'd32767;
    if (s == 20'd0) begin
      e.cx = '0; e.cy = '0; e.nt = 1'b1; e.ovf = 1'b0;
    end else begin
      qx = quot(sx, s);
      qy = quot(sy, s);
      e.nt  = 1'b0;
      e.ovf = (qx > lim) || (qy > lim);
      e.cx  = (qx > lim) ? 15'h7fff : qx[OW-1:0];
      e.cy  = (qy > lim) ? 15'h7fff : qy[OW-1:0];
    end
    return e;
  endfunction

  // Pops the oldest expectation against the presented result, then checks
  // the handshake completes on the following cycle.
  task automatic collect(input string tag);
    exp_t e;
    chk({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_cx"},  32'(oCX), 32'(e.cx));
      chk({tag, "_cy"},  32'(oCY), 32'(e.cy));
      chk({tag, "_nt"},  32'(oNO_TARGET), 32'(e.nt));
      chk({tag, "_ovf"}, 32'(oOVF), 32'(e.ovf));
    end
    @(negedge CCLK);
    chk({tag, "_vld_drop"},  32'(oVALID), 32'd0);
    chk({tag, "_busy_drop"}, 32'(oBUSY), 32'd0);
    chk({tag, "_idle"},      32'(oSTATE), 32'd0);
  endtask

  task automatic run_txn(input logic [19:0] s, input logic [27:0] sx, input logic [27:0] sy,
                         input string tag);
    int lat;
    sb.push_back(model(s, sx, sy));
    @(negedge CCLK);
    iSUM_S = s; iSUM_SX = sx; iSUM_SY = sy; iSTART_TRIG = 1'b1;
    lat = 0;
    do begin
      @(negedge CCLK);
      lat++;
      if (lat == 1) begin
        iSTART_TRIG = 1'b0;
        chk({tag, "_busy_rise"}, 32'(oBUSY), 32'd1);
      end
    end while (!oVALID && lat < 500);
    chk({tag, "_latency"}, 32'(lat), (s == 20'd0) ? 32'd2 : 32'(LAT));
    collect(tag);
  endtask

  initial begin
    int   lat;
    int   n_vld;
    exp_t h;
    RST_N = 1'b0; iSTART_TRIG = 1'b0; iREADY = 1'b1;
    iSUM_S = '0; iSUM_SX = '0; iSUM_SY = '0;
    repeat (3) @(negedge CCLK);
    chk("rst_busy",  32'(oBUSY), 32'd0);
    chk("rst_valid", 32'(oVALID), 32'd0);
    chk("rst_cx",    32'(oCX), 32'd0);
    chk("rst_cy",    32'(oCY), 32'd0);
    chk("rst_nt",    32'(oNO_TARGET), 32'd0);
    chk("rst_ovf",   32'(oOVF), 32'd0);
    chk("rst_state", 32'(oSTATE), 32'd0);
    RST_N = 1'b1;
    @(negedge CCLK);

    run_txn(20'd100, 28'd32000, 28'd24000, "c320");
    run_txn(20'd3, 28'd5, 28'd7, "small");
    run_txn(20'd0, 28'd1234, 28'd5678, "zero");
    run_txn(20'd1, 28'h8000000, 28'd5, "sat");
    run_txn(20'd7, 28'd700, 28'd1400, "after_sat");

    // Back-pressure with stray triggers during DIV_Y and OUT.
    iREADY = 1'b0;
    sb.push_back(model(20'd100, 28'd50000, 28'd70000));
    @(negedge CCLK);
    iSUM_S = 20'd100; iSUM_SX = 28'd50000; iSUM_SY = 28'd70000; iSTART_TRIG = 1'b1;
    lat = 0;
    do begin
      @(negedge CCLK);
      lat++;
      if (lat == 1)  iSTART_TRIG = 1'b0;
      if (lat == 40) iSTART_TRIG = 1'b1;
      if (lat == 41) iSTART_TRIG = 1'b0;
    end while (!oVALID && lat < 500);
    chk("hold_latency", 32'(lat), 32'(LAT));
    h = sb[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge CCLK);
      if (i == 3) iSTART_TRIG = 1'b1;
      if (i == 4) iSTART_TRIG = 1'b0;
      chk("hold_valid", 32'(oVALID), 32'd1);
      chk("hold_cx",    32'(oCX), 32'(h.cx));
      chk("hold_cy",    32'(oCY), 32'(h.cy));
      chk("hold_busy",  32'(oBUSY), 32'd1);
    end
    iREADY = 1'b1;
    collect("hold");
    n_vld = 0;
    repeat (80) begin
      @(negedge CCLK);
      if (oVALID) n_vld++;
    end
    chk("no_extra_result", 32'(n_vld), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Reset in the middle of the X divide.
    @(negedge CCLK);
    iSUM_S = 20'd100; iSUM_SX = 28'd32000; iSUM_SY = 28'd24000; iSTART_TRIG = 1'b1;
    @(negedge CCLK);
    iSTART_TRIG = 1'b0;
    repeat (8) @(negedge CCLK);
    chk("pre_rst_state", 32'(oSTATE), 32'd1);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_busy",  32'(oBUSY), 32'd0);
    chk("mid_rst_state", 32'(oSTATE), 32'd0);
    chk("mid_rst_cx",    32'(oCX), 32'd0);
    chk("mid_rst_valid", 32'(oVALID), 32'd0);
    @(negedge CCLK);
    RST_N = 1'b1;
    @(negedge CCLK);
    chk("post_rst_state", 32'(oSTATE), 32'd0);
    run_txn(20'd7, 28'd700, 28'd1400, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
